// File: rtl/impl_arbiter.sv
// impl_arbiter: round-robin scheduler sharing one bit-serial implication unit
// (y = ~a | b) among four requesters. The granted requester's operands are
// latched at the grant and evaluated LSB first, one bit per cycle. The block
// then reports the word result, a tautology flag and a one-cycle ack.
module impl_arbiter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] a_in,
    input  logic [4*W-1:0] b_in,
    output logic           busy,
    output logic [1:0]     grant_id,
    output logic           done,
    output logic [3:0]     ack,
    output logic [W-1:0]   result,
    output logic           all_true
);

    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      gid_q, gid_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    res_q, res_d;
    logic            allt_q, allt_d;

    logic [1:0]      sel;
    logic [1:0]      cand;
    logic [W-1:0]    acc_bit;

    // Pick the first requester at or after the pointer (modulo 4); walking the
    // offsets downward lets the closest hit overwrite the farther ones.
    always_comb begin
        sel  = ptr_q;
        cand = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                sel = cand;
            end
        end
    end

    // Accumulator with the current bit of the serial implication merged in.
    always_comb begin
        acc_bit        = acc_q;
        acc_bit[idx_q] = ~opa_q[idx_q] | opb_q[idx_q];
    end

    // Next-state and datapath control for the IDLE / EVAL / DONE sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        allt_d  = allt_q;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    gid_d   = sel;
                    opa_d   = a_in[int'(sel) * W +: W];
                    opb_d   = b_in[int'(sel) * W +: W];
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                acc_d = acc_bit;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    // Publish the finished word as DONE is entered.
                    idx_d   = '0;
                    res_d   = acc_bit;
                    allt_d  = &acc_bit;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The served requester drops to lowest priority next round.
                ptr_d   = gid_q + 2'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            allt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            allt_q  <= allt_d;
        end
    end

    // Operand latches; only meaningful after a grant, so no reset needed.
    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign ack      = done ? (4'b0001 << gid_q) : 4'b0000;
    assign grant_id = gid_q;
    assign result   = res_q;
    assign all_true = allt_q;

endmodule

// File: tb/tb_impl_arbiter.sv
// tb_impl_arbiter: directed scenarios plus randomized traffic, compared every
// cycle against a transaction-level reference of the round-robin scheduler.
module tb_impl_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     req;
    logic [4*W-1:0] a_in;
    logic [4*W-1:0] b_in;
    logic           busy;
    logic [1:0]     grant_id;
    logic           done;
    logic [3:0]     ack;
    logic [W-1:0]   result;
    logic           all_true;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    impl_arbiter #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done),
        .ack      (ack),
        .result   (result),
        .all_true (all_true)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: remaining busy cycles of the current job, pointer, winner and
    // the word result computed in one step from the latched operands.
    int           m_cnt  = 0;
    int           m_ptr  = 0;
    int           m_gid  = 0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    logic [W-1:0] m_res  = '0;
    bit           m_allt = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt  = 0;
            m_ptr  = 0;
            m_gid  = 0;
            m_res  = '0;
            m_allt = 1'b0;
        end else if (m_cnt == 0) begin
            if (req != 4'b0000) begin
                bit found;
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (m_ptr + k) % 4;
                    if (!found && req[j]) begin
                        m_gid = j;
                        found = 1'b1;
                    end
                end
                m_a   = a_in[m_gid*W +: W];
                m_b   = b_in[m_gid*W +: W];
                m_cnt = W + 1;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 1) begin
                m_res  = ~m_a | m_b;
                m_allt = (m_res == {W{1'b1}});
            end
            if (m_cnt == 0) begin
                m_ptr = (m_gid + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy",     busy,     m_cnt != 0);
            check("done",     done,     m_cnt == 1);
            check("ack",      ack,      (m_cnt == 1) ? (4'b0001 << m_gid) : 4'b0000);
            check("grant_id", grant_id, m_gid);
            check("result",   result,   m_res);
            check("all_true", all_true, m_allt);
        end
    end

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check("done_seen", done, 1'b1);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset: nothing may move.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_outs", {grant_id, done, ack, result, all_true}, '0);
        end

        // Single request from requester 0.
        set_ops(0, 8'hF0, 8'h30);
        req = 4'b0001;
        wait_done(40, n);
        check("single_latency", n, 9);
        check("single_result", result, 8'h3F);
        check("single_alltrue", all_true, 1'b0);
        check("single_ack", ack, 4'b0001);
        check("single_gid", grant_id, 2'd0);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Tautology from requester 2.
        set_ops(2, 8'h55, 8'hFF);
        req = 4'b0100;
        wait_done(40, n);
        check("taut_result", result, 8'hFF);
        check("taut_alltrue", all_true, 1'b1);
        check("taut_ack", ack, 4'b0100);
        req = 4'b0000;
        @(negedge clk);

        // Round-robin with all four requesting, starting from pointer 0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_ops(i, W'($urandom), W'($urandom));
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_done(40, n);
            check("rr_gap", n, (g == 0) ? 9 : 10);
            check("rr_gid", grant_id, g % 4);
            check("rr_ack", ack, 4'b0001 << (g % 4));
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Operand change and req drop mid-EVAL for requester 1.
        set_ops(1, 8'hA5, 8'h0F);
        req = 4'b0010;
        repeat (3) @(negedge clk);
        a_in[1*W +: W] = 8'hFF;
        req = 4'b0000;
        wait_done(40, n);
        check("drop_result", result, 8'h5F);
        check("drop_ack", ack, 4'b0010);
        repeat (2) @(negedge clk);

        // Reset in the middle of an operation.
        set_ops(2, 8'h12, 8'h34);
        req = 4'b0100;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort_done", {done, ack}, 5'b0);
            check("abort_outs", {busy, grant_id, result, all_true}, '0);
        end
        req = 4'b1111;
        wait_done(40, n);
        check("post_reset_gid", grant_id, 2'd0);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Randomized traffic, occasional resets, biased toward tautologies.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                logic [W-1:0] a;
                a = W'($urandom);
                a_in[i*W +: W] = a;
                case ($urandom_range(0, 3))
                    0:       b_in[i*W +: W] = {W{1'b1}};
                    1:       b_in[i*W +: W] = a;
                    default: b_in[i*W +: W] = W'($urandom);
                endcase
            end
            reset = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        req   = 4'b0000;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
